// File: rtl/vga_stream_timing.sv
// rtl/vga_stream_timing.sv - Avalon-ST pixel sink with FIFO and VGA raster timing
module vga_stream_timing #(
  parameter int DATA_WIDTH = 30,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  startofpacket,
  input  logic                  endofpacket,
  input  logic                  valid,
  output logic                  ready,
  output logic [9:0]            vga_r,
  output logic [9:0]            vga_g,
  output logic [9:0]            vga_b,
  output logic                  vga_hsync_n,
  output logic                  vga_vsync_n,
  output logic                  vga_blank_n,
  output logic                  frame_locked,
  output logic                  sync_err
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int EW      = DATA_WIDTH + 2;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] H_SS       = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE       = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_SS       = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE       = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] CNT_FULL   = CW'(FIFO_DEPTH);

  localparam logic [0:0] SYNC_WAIT = 1'b0;
  localparam logic [0:0] RUN       = 1'b1;

  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  push, pop, empty;
  logic [EW-1:0]         head;
  logic                  head_sop, head_eop;
  logic [DATA_WIDTH-1:0] head_data;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          active, at_origin, at_last, hs_win, vs_win;

  logic [0:0] state, next_state;
  logic       show, set_err;

  assign ready     = (count != CNT_FULL);
  assign push      = valid && ready;
  assign empty     = (count == '0);
  assign head      = mem[rd_ptr];
  assign head_sop  = head[EW-1];
  assign head_eop  = head[EW-2];
  assign head_data = head[DATA_WIDTH-1:0];

  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  assign at_last   = (h_cnt == H_ACT_LAST) && (v_cnt == V_ACT_LAST);
  assign hs_win    = (h_cnt >= H_SS) && (h_cnt < H_SE);
  assign vs_win    = (v_cnt >= V_SS) && (v_cnt < V_SE);

  assign frame_locked = (state == RUN);

  // FIFO storage: entries carry {sop, eop, data}; contents need no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {startofpacket, endofpacket, data};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Free-running raster counters, independent of lock state
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // Lock/run decisions: which head word to pop, show or reject this position
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    show       = 1'b0;
    set_err    = 1'b0;
    if (state == SYNC_WAIT) begin
      if (!empty) begin
        if (!head_sop) begin
          pop = 1'b1;
        end else if (at_origin) begin
          pop        = 1'b1;
          show       = 1'b1;
          next_state = RUN;
        end
      end
    end else if (active) begin
      if (empty) begin
        set_err    = 1'b1;
        next_state = SYNC_WAIT;
      end else if (at_origin) begin
        if (head_sop) begin
          pop  = 1'b1;
          show = 1'b1;
        end else begin
          set_err    = 1'b1;
          next_state = SYNC_WAIT;
        end
      end else if (head_sop) begin
        // An early SOP is kept at the head so the next frame can lock on it
        set_err    = 1'b1;
        next_state = SYNC_WAIT;
      end else begin
        pop  = 1'b1;
        show = 1'b1;
        if (at_last && !head_eop) begin
          set_err    = 1'b1;
          next_state = SYNC_WAIT;
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= SYNC_WAIT;
    else       state <= next_state;
  end

  // Registered VGA outputs, one cycle behind the counters they describe
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hsync_n <= 1'b1;
      vga_vsync_n <= 1'b1;
      vga_blank_n <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      vga_r       <= show ? head_data[29:20] : '0;
      vga_g       <= show ? head_data[19:10] : '0;
      vga_b       <= show ? head_data[9:0]   : '0;
      vga_hsync_n <= !hs_win;
      vga_vsync_n <= !vs_win;
      vga_blank_n <= active;
      sync_err    <= sync_err || set_err;
    end
  end

endmodule

// File: tb/tb_vga_stream_timing.sv
// tb/tb_vga_stream_timing.sv - directed bench for vga_stream_timing on a reduced raster
module tb_vga_stream_timing;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int DEPTH = 4;
  localparam int HT = 16, VT = 8, NPIX = 32;
  localparam int NEVER = 1 << 30;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [29:0] data = '0;
  logic        sop = 1'b0, eop = 1'b0, valid = 1'b0;
  logic        ready;
  logic [9:0]  vga_r, vga_g, vga_b;
  logic        vga_hsync_n, vga_vsync_n, vga_blank_n, frame_locked, sync_err;

  int t = 0;
  int n_tests = 0, n_fail = 0;
  int src_idx = 0, src_inj = -1;
  bit src_en = 1'b0;
  logic rdy_s = 1'b0;
  int win_hs_low, win_vs_low;

  vga_stream_timing #(
    .DATA_WIDTH(30), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .data(data), .startofpacket(sop),
    .endofpacket(eop), .valid(valid), .ready(ready),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync_n(vga_hsync_n), .vga_vsync_n(vga_vsync_n),
    .vga_blank_n(vga_blank_n), .frame_locked(frame_locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  // cycle index since the last reset edge; counters read (t%HT, (t/HT)%VT) in cycle t
  always @(posedge clk) t <= reset ? 0 : t + 1;

  always @(negedge clk) rdy_s = ready;

  function automatic logic [29:0] pix(input int idx);
    logic [9:0] i;
    i = 10'(idx);
    return {i ^ 10'h155, i ^ 10'h2AA, i};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic wait_t(input int n);
    while (t < n) @(negedge clk);
  endtask

  task automatic do_reset();
    src_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // compare outputs each cycle against the raster position of the previous cycle
  task automatic check_window(input string tag, input int t_from, input int t_to, input int lock_t);
    int e_rgb, e_hs, e_vs, e_bl, e_lk;
    int p, h, y;
    bit act;
    logic [29:0] exp_rgb;
    e_rgb = 0; e_hs = 0; e_vs = 0; e_bl = 0; e_lk = 0;
    win_hs_low = 0; win_vs_low = 0;
    wait_t(t_from);
    while (t <= t_to) begin
      p = t - 1;
      h = p % HT;
      y = (p / HT) % VT;
      act = (h < HA) && (y < VA);
      exp_rgb = (t >= lock_t && act) ? pix(y * HA + h) : 30'd0;
      if ({vga_r, vga_g, vga_b} !== exp_rgb) e_rgb++;
      if (vga_hsync_n !== !(h >= HA + HF && h < HA + HF + HS)) e_hs++;
      if (vga_vsync_n !== !(y >= VA + VF && y < VA + VF + VS)) e_vs++;
      if (vga_blank_n !== act) e_bl++;
      if (frame_locked !== (t >= lock_t)) e_lk++;
      if (vga_hsync_n === 1'b0) win_hs_low++;
      if (vga_vsync_n === 1'b0) win_vs_low++;
      @(negedge clk);
    end
    check_eq({tag, "_rgb_errs"}, e_rgb, 0);
    check_eq({tag, "_hsync_errs"}, e_hs, 0);
    check_eq({tag, "_vsync_errs"}, e_vs, 0);
    check_eq({tag, "_blank_errs"}, e_bl, 0);
    check_eq({tag, "_lock_errs"}, e_lk, 0);
  endtask

  // upstream source: word k carries pix(k), sop on k==0 or on the injected index
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (valid && rdy_s) begin
        if (src_idx == src_inj) src_inj = -1;
        src_idx = (src_idx + 1) % NPIX;
      end
      valid = src_en;
      data  = pix(src_idx);
      sop   = (src_idx == 0) || (src_idx == src_inj);
      eop   = (src_idx == NPIX - 1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values and idle raster
    do_reset();
    check_eq("rst_ready", ready, 1);
    check_eq("rst_rgb", {vga_r, vga_g, vga_b}, 0);
    check_eq("rst_hsync_n", vga_hsync_n, 1);
    check_eq("rst_vsync_n", vga_vsync_n, 1);
    check_eq("rst_blank_n", vga_blank_n, 0);
    check_eq("rst_locked", frame_locked, 0);
    check_eq("rst_sync_err", sync_err, 0);
    check_window("idle", 1, 256, NEVER);
    check_eq("idle_hsync_low_cycles", win_hs_low, 48);
    check_eq("idle_vsync_low_cycles", win_vs_low, 64);
    check_eq("idle_ready", ready, 1);

    // continuous stream: lock at first (0,0) after the FIFO holds the SOP
    do_reset();
    src_idx = 0; src_inj = -1; src_en = 1'b1;
    check_window("stream", 1, 406, 129);
    check_eq("stream_sync_err", sync_err, 0);

    // underflow mid-frame, then resume mid-stream and relock
    src_en = 1'b0;
    check_window("underflow", 430, 459, NEVER);
    check_eq("underflow_sync_err", sync_err, 1);
    src_idx = 20; src_en = 1'b1;
    check_window("relock", 460, 640, 513);
    check_eq("relock_sync_err_sticky", sync_err, 1);

    // upstream starts mid-frame with trailing words before SOP
    do_reset();
    wait_t(34);
    src_idx = 28; src_inj = -1; src_en = 1'b1;
    wait_t(100);
    check_eq("mid_fifo_full_ready", ready, 0);
    check_eq("mid_unlocked", frame_locked, 0);
    check_window("midstart", 101, 200, 129);
    check_eq("mid_sync_err", sync_err, 0);

    // early SOP on word 5 of a locked frame
    do_reset();
    src_idx = 0; src_inj = -1; src_en = 1'b1;
    wait_t(10);
    src_inj = 5;
    check_window("inject_pre", 11, 133, 129);
    check_eq("inject_rgb_black", {vga_r, vga_g, vga_b}, 0);
    check_eq("inject_sync_err", sync_err, 1);
    check_eq("inject_unlocked", frame_locked, 0);
    wait_t(148);
    check_eq("inject_wait_blank_n", vga_blank_n, 1);
    check_eq("inject_wait_rgb", {vga_r, vga_g, vga_b}, 0);
    wait_t(257);
    check_eq("inject_next_origin", {vga_r, vga_g, vga_b}, pix(5));
    check_eq("inject_relocked", frame_locked, 1);
    @(negedge clk);
    check_eq("inject_next_pixel1", {vga_r, vga_g, vga_b}, pix(6));

    // one-cycle reset while locked at (5,2)
    wait_t(293);
    check_eq("midrst_pre_locked", frame_locked, 1);
    check_eq("midrst_pre_err", sync_err, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("midrst_ready", ready, 1);
    check_eq("midrst_rgb", {vga_r, vga_g, vga_b}, 0);
    check_eq("midrst_hsync_n", vga_hsync_n, 1);
    check_eq("midrst_vsync_n", vga_vsync_n, 1);
    check_eq("midrst_blank_n", vga_blank_n, 0);
    check_eq("midrst_locked", frame_locked, 0);
    check_eq("midrst_sync_err", sync_err, 0);
    @(negedge clk);
    check_eq("midrst_origin_blank_n", vga_blank_n, 1);
    check_eq("midrst_origin_rgb", {vga_r, vga_g, vga_b}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_stream_timing.md
Name: vga_stream_timing

Overview:
- Downstream consumer of the 640x480 Avalon-ST pixel source (30-bit RGB, 10 bits per channel, with startofpacket/endofpacket).
- Buffers the stream in a small FIFO and generates standard VGA raster timing: hsync, vsync and blank.
- Pops one pixel per active raster position and locks each frame to startofpacket.
- On underflow or packet misalignment it blanks to black and resynchronises, so the upstream generator never needs to know about raster timing.

Parameters:
- DATA_WIDTH, 30: pixel word width, {R[29:20], G[19:10], B[9:0]}.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync pulse width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync pulse width, in lines.
- V_BP, 33: vertical back porch, in lines.
- FIFO_DEPTH, 16: entries in the input FIFO; power of two, at least 4.

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- data  in  DATA_WIDTH  Avalon-ST pixel data
- startofpacket  in  1  first pixel of a frame
- endofpacket  in  1  last pixel of a frame
- valid  in  1  upstream word valid
- ready  out  1  sink can accept a word
- vga_r  out  10  red
- vga_g  out  10  green
- vga_b  out  10  blue
- vga_hsync_n  out  1  horizontal sync, active low
- vga_vsync_n  out  1  vertical sync, active low
- vga_blank_n  out  1  high during the active area
- frame_locked  out  1  high while in RUN
- sync_err  out  1  sticky: underflow or misalignment seen since reset

Behaviour:
- Reset is synchronous, active-high, on clk. It clears:
  - the FIFO, to empty;
  - h_cnt and v_cnt, to 0;
  - the state, to SYNC_WAIT;
  - vga_r/g/b to 0, hsync_n and vsync_n to 1, blank_n to 0, frame_locked to 0, sync_err to 0.
- Reset asserted mid-frame has the same effect; buffered words are discarded.
- FIFO:
  - Each entry is {sop, eop, data}.
  - ready = (count != FIFO_DEPTH), decoded from the registered count. There is no combinational pass-through; a full FIFO deasserts ready even if a pop happens in the same cycle.
  - A push occurs when valid & ready.
  - Simultaneous push and pop leaves count unchanged.
  - The head entry is visible combinationally.
- Timing counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = sum of the H parameters (800).
  - v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1, where V_TOTAL = sum of the V parameters (525).
  - Counters free-run in every state.
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hsync is asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync uses the analogous V window.
- Output latency:
  - All VGA outputs are registered, exactly 1 cycle after the counter values they correspond to.
  - Syncs, blank and RGB stay mutually aligned.
  - RGB is 0 whenever not active, or whenever no pixel is popped for the current position.
- SYNC_WAIT state:
  - Pop and discard the head whenever it is non-empty and its sop = 0.
  - When the head has sop = 1, hold it.
  - Move to RUN in the cycle where h_cnt = 0, v_cnt = 0 and head sop = 1. In that same cycle pop the head and display it as pixel (0,0).
  - Output stays black throughout.
- RUN state, on each active position:
  - FIFO empty: output black, set sync_err, go to SYNC_WAIT.
  - Head sop = 1 at any position other than (0,0): do not pop, output black, set sync_err, go to SYNC_WAIT. The held SOP is used on the next frame.
  - Position (0,0) with head sop = 0: output black, set sync_err, go to SYNC_WAIT.
  - Position (H_ACTIVE-1, V_ACTIVE-1) with head eop = 0: pop and display the pixel, set sync_err, go to SYNC_WAIT.
  - Otherwise: pop the head and display its data.
- RUN state, off the active area: no pops.
- frame_locked = (state == RUN), registered with the other outputs.
- sync_err is cleared only by reset.

Test Plan:
- Reset, then idle with valid = 0:
  - ready = 1, vga_blank_n = 0 after reset, frame_locked = 0.
  - hsync_n low for 96 cycles every 800.
  - vsync_n low for 2 lines (1600 cycles) every 525 lines.
- Upstream streams a full 307200-word frame (data = pixel index, SOP/EOP correct) with ready honoured:
  - Lock occurs at the first (0,0).
  - Output pixel (x,y) = y*640+x, delivered 1 cycle after the counter position.
  - Two consecutive frames complete with sync_err = 0.
- Start upstream mid-frame, with sop arriving while v_cnt = 200:
  - SOP is held; the FIFO fills to 16 and ready = 0.
  - Lock occurs at the next (0,0), with the first output data = SOP word.
- After lock, hold valid = 0 for 1000 cycles during active video:
  - Black output and sync_err = 1.
  - Return to SYNC_WAIT; relock on the next SOP at (0,0).
- Inject sop = 1 on word 100 of a locked frame:
  - Position (100,0) outputs black with no pop; sync_err = 1.
  - That word becomes pixel (0,0) of the next frame.
- Assert reset for 1 cycle at h_cnt = 300, v_cnt = 50 while locked:
  - Next cycle: counters = 0, FIFO empty (ready = 1), all outputs at their reset values, sync_err = 0.
